// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter control front panel.
// Optional debounce filtering is enabled with COUNTER_CTRL_DEBOUNCE_EN.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // 20 ms of stable level at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/counter_ctrl_btn.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce filter
// (COUNTER_CTRL_DEBOUNCE_EN), rising-edge detect giving a one-cycle press.
module btn_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic stable;
  logic stable_d;
  logic press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef COUNTER_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counter runs only while the synchronized level disagrees with the
  // accepted level; the >= compare keeps it from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign stable = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      stable_d <= stable;
      press_q  <= stable & ~stable_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Front-panel controller: four conditioned pushbuttons drive an IDLE/RUN/HALT
// FSM issuing start/stop/load pulses. Debounce enabled by COUNTER_CTRL_DEBOUNCE_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_load,
  input  logic       btn_ud,
  input  logic [3:0] sw_digit,
  output logic       start,
  output logic       stop,
  output logic       load,
  output logic       ud,
  output logic [3:0] digit,
  output logic       running,
  output state_t     fsm_state
);

  logic start_ev;
  logic stop_ev;
  logic load_ev;
  logic ud_ev;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk_50M), .rst(reset), .btn(btn_start), .press(start_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk(clk_50M), .rst(reset), .btn(btn_stop), .press(stop_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk_50M), .rst(reset), .btn(btn_load), .press(load_ev));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ud (
    .clk(clk_50M), .rst(reset), .btn(btn_ud), .press(ud_ev));

  state_t     state;
  state_t     state_n;
  logic       pend;
  logic       pend_n;
  logic       go;
  logic       start_n;
  logic       stop_n;
  logic       load_n;
  logic       ud_n;
  logic [3:0] digit_n;

  // pend defers a start that arrived together with a load by one cycle,
  // so load and start never pulse together.
  assign go = (start_ev | pend) & ~stop_ev;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 1'b0;
      start <= 1'b0;
      stop  <= 1'b0;
      load  <= 1'b0;
      ud    <= 1'b0;
      digit <= 4'd0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      start <= start_n;
      stop  <= stop_n;
      load  <= load_n;
      ud    <= ud_n;
      digit <= digit_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = 1'b0;
    start_n = 1'b0;
    stop_n  = 1'b0;
    load_n  = 1'b0;
    ud_n    = ud ^ ud_ev;
    digit_n = digit;
    case (state)
      RUN: begin
        if (stop_ev) begin
          state_n = HALT;
          stop_n  = 1'b1;
        end
      end
      default: begin
        if (load_ev) begin
          load_n  = 1'b1;
          digit_n = sw_digit;
          pend_n  = go;
        end else if (go) begin
          state_n = RUN;
          start_n = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    running   = (state == RUN);
    fsm_state = state;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a button level (20 ms at 50 MHz).
REQ-002 clk_50M  input  1  sole clock, 50 MHz, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 btn_start  input  1  raw, asynchronous start pushbutton, active-high.
REQ-005 btn_stop  input  1  raw stop pushbutton, active-high.
REQ-006 btn_load  input  1  raw load pushbutton, active-high.
REQ-007 btn_ud  input  1  raw direction pushbutton; each accepted press toggles ud.
REQ-008 sw_digit  input  4  slide-switch preset value, quasi-static.
REQ-009 start  output  1  one-cycle pulse, counter start command.
REQ-010 stop  output  1  one-cycle pulse, counter stop command.
REQ-011 load  output  1  one-cycle pulse, counter preset command.
REQ-012 ud  output  1  count direction level, 1 = up.
REQ-013 digit  output  4  registered preset value, valid whenever load is high.
REQ-014 running  output  1  level, high while FSM in RUN.

Function
REQ-015 Each btn_* SHALL pass a 2-flop synchronizer, then debounce, then rising-edge detect, producing a one-cycle press event.
REQ-016 Debounce: stable level SHALL change only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion SHALL clear the counter to 0.
REQ-017 Latency from first clk_50M edge sampling a clean button high to the output pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-018 Release events SHALL produce no output.
REQ-019 FSM states SHALL be IDLE, RUN, HALT; reset state IDLE.
REQ-020 IDLE or HALT + start event -> RUN, start pulse same cycle as transition.
REQ-021 RUN + stop event -> HALT, stop pulse; stop event in IDLE/HALT ignored, no pulse.
REQ-022 Start event in RUN SHALL be ignored, no pulse.
REQ-023 Start and stop events in same cycle: stop wins (RUN -> HALT with stop pulse; IDLE/HALT unchanged, no pulse).
REQ-024 Load event in IDLE or HALT SHALL pulse load and capture sw_digit into digit on that cycle; load event in RUN ignored, digit unchanged.
REQ-025 Load and start events in same cycle from IDLE/HALT: load pulse and digit capture SHALL occur that cycle, start pulse one cycle later with transition to RUN.
REQ-026 ud event SHALL toggle ud in any state; ud SHALL never change otherwise.
REQ-027 start, stop, load SHALL never be high in the same cycle, and none SHALL be high two consecutive cycles from a single press.

Reset
REQ-028 Reset SHALL force start=stop=load=0, ud=0, digit=0, running=0, state IDLE, synchronizers, stable levels and debounce counters to 0.
REQ-029 A button held across reset deassertion SHALL be debounced from zero and produce exactly one press event.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no event.

Configuration
REQ-031 Macro COUNTER_CTRL_DEBOUNCE_EN defined: debounce per REQ-016/017.
REQ-032 Macro undefined: debounce counters removed, stable level = synchronized input, latency exactly 3 cycles, DEBOUNCE_CYCLES ignored; all FSM behaviour unchanged.

Structure
REQ-033 Package counter_ctrl_pkg SHALL hold the FSM state enum (IDLE, RUN, HALT) and default DEBOUNCE_CYCLES constant.
REQ-034 Sub-module btn_debounce (sync + debounce + edge detect, press output) SHALL be instantiated four times.
REQ-035 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; counter SHALL saturate, never wrap.

Verification (DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-036 Reset released, btn_start high clean -> start pulse 7 cycles later, running=1; further start presses give no pulse.
REQ-037 btn_load bouncing 1,0,1,0 each cycle then high 10 cycles in IDLE, sw_digit=4'b1010 -> exactly one load pulse, digit=4'b1010.
REQ-038 RUN, btn_start and btn_stop rise same edge -> one stop pulse, running=0, no start pulse.
REQ-039 RUN, btn_load press with sw_digit=4'b0011 -> no load pulse, digit unchanged; btn_ud pressed twice -> ud 0->1->0.
REQ-040 Reset asserted 2 cycles into btn_stop debounce -> all outputs 0 at once, no stop pulse; macro undefined: btn_start -> start pulse 3 cycles later.
